vga_pattern_gen: RTL and testbench
==================================

Name: vga_pattern_gen

Overview:
- Test-pattern source feeding the R_i/G_i/B_i inputs of the VGA output stage.
- Consumes the pixel coordinates and display-active flag from the sync generator, plus the 4-bit mode from the mode counter.
- Produces registered 8-bit RGB with a fixed 2-cycle latency, and a matching delayed display-enable.
- Mode changes take effect only on frame boundaries, so no frame ever shows a torn pattern.

Parameters:
- H_ACTIVE, 640: active pixels per line; last active column is H_ACTIVE-1.
- V_ACTIVE, 480: active lines per frame; last active row is V_ACTIVE-1.
- BAR_W, 80: width in pixels of each colour bar in mode 2.
- CHECK_LOG2, 5: checkerboard square size is 2^CHECK_LOG2 pixels.

Ports:
- clk  in  1  pixel clock.
- rst  in  1  asynchronous reset, active-low.
- Xpos  in  12  current pixel column from the sync generator.
- Ypos  in  12  current pixel row from the sync generator.
- Disp_activ  in  1  high while Xpos/Ypos lie inside the active area.
- mode  in  4  requested pattern select.
- R_o  out  8  red pixel value.
- G_o  out  8  green pixel value.
- B_o  out  8  blue pixel value.
- de_o  out  1  Disp_activ delayed by 2 cycles.
- frame_cnt_o  out  8  current frame counter value.

Behaviour:
- Reset (rst=0, asynchronous): R_o=G_o=B_o=0, de_o=0, frame_cnt_o=0; the active mode register is cleared to 0 (black); all pipeline registers are cleared. Outputs are driven from the next rising edge after rst returns high.
- Frame start is the cycle where Disp_activ=1, Xpos=0 and Ypos=0.
  - On that cycle the active mode register loads mode.
  - On that cycle frame_cnt increments by 1, wrapping 255 -> 0.
  - That pixel is rendered with the newly loaded mode and the incremented count.
  - A mode change at any other cycle is ignored until the next frame start.
- Pipeline:
  - Stage 1 registers Xpos, Ypos, Disp_activ and the effective mode.
  - Stage 2 computes the pattern from the stage-1 values and registers RGB and de_o.
  - The pixel sampled at cycle n appears on the outputs at cycle n+2.
- When the stage-2 display-enable is 0, RGB=0 regardless of mode.
- Patterns by effective mode (RGB written as 24-bit hex, R high byte):
  - 0: black, 000000.
  - 1: white, FFFFFF.
  - 2: eight colour bars. Index i = Xpos / BAR_W, clamped to 7. Order: white FFFFFF, yellow FFFF00, cyan 00FFFF, green 00FF00, magenta FF00FF, red FF0000, blue 0000FF, black 000000.
  - 3: checkerboard. White where Xpos[CHECK_LOG2] XOR Ypos[CHECK_LOG2] = 1, otherwise black.
  - 4: grey horizontal ramp, R=G=B=Xpos[7:0]; wraps every 256 columns.
  - 5: moving bar. White where Xpos[9:4] == frame_cnt[5:0], otherwise black. The bar is 16 px wide and steps 16 px per frame.
  - 6: solid red FF0000. 7: solid green 00FF00. 8: solid blue 0000FF.
  - 9-15: black.
- Coordinates at or beyond H_ACTIVE/V_ACTIVE while Disp_activ=1 are rendered by the same formulas; no special handling.
- If rst is asserted mid-frame, everything clears immediately. Patterns resume in mode 0 until the next frame start loads mode.

Optional Feature:
- Macro: VGA_PGEN_BORDER_EN.
- Defined: a 1-pixel white (FFFFFF) border is drawn where Xpos=0, Xpos=H_ACTIVE-1, Ypos=0 or Ypos=V_ACTIVE-1 while display-enable is active. The border overrides every mode except mode 0. Latency is unchanged.
- Undefined: no border logic is present, and edge pixels follow the selected pattern.

Test Plan:
- Reset: hold rst=0 for 5 clk with Disp_activ toggling -> RGB=000000, de_o=0, frame_cnt_o=0 throughout; after release, mode stays 0 until the first frame start.
- Colour bars: mode=2 latched at frame start; drive Xpos=0, 79, 80, 400, 639 with Disp_activ=1 -> two cycles later RGB=FFFFFF, FFFFFF, FFFF00, FF0000, 000000.
- Mid-frame mode change: in mode 1, set mode=6 at Ypos=100 -> RGB stays FFFFFF for the rest of the frame; next frame (0,0) outputs FF0000.
- Blanking: mode=1, Disp_activ=0 at Xpos=700 -> RGB=000000 and de_o=0 exactly 2 cycles later; de_o tracks Disp_activ with 2-cycle delay.
- Moving bar and wrap: run 256 frame starts in mode 5 -> frame_cnt_o goes 255 -> 0; at frame_cnt=3, Xpos=48..63 white, Xpos=47 and 64 black.
- Border (VGA_PGEN_BORDER_EN defined): mode=6, pixel (0,10) -> FFFFFF; pixel (1,10) -> FF0000; mode 0 at (0,0) -> 000000.

Source files
------------

// File: rtl/vga_pattern_gen.sv
// vga_pattern_gen: test-pattern source for the VGA output stage.
// Two-stage pipeline: stage 1 captures coordinates, display-active and the
// effective mode; stage 2 renders the pattern and registers RGB and de_o.
// Optional 1-pixel white border is compiled in when VGA_PGEN_BORDER_EN is defined.
module vga_pattern_gen #(
  parameter int H_ACTIVE   = 640,
  parameter int V_ACTIVE   = 480,
  parameter int BAR_W      = 80,
  parameter int CHECK_LOG2 = 5
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [11:0] Xpos,
  input  logic [11:0] Ypos,
  input  logic        Disp_activ,
  input  logic [3:0]  mode,
  output logic [7:0]  R_o,
  output logic [7:0]  G_o,
  output logic [7:0]  B_o,
  output logic        de_o,
  output logic [7:0]  frame_cnt_o
);

  logic        frame_start;
  logic [3:0]  active_mode;
  logic [7:0]  frame_cnt;
  logic [3:0]  eff_mode;
  logic [7:0]  eff_cnt;

  logic [11:0] s1_x;
  logic        s1_y_bit;
  logic        s1_de;
  logic [3:0]  s1_mode;
  logic [5:0]  s1_cnt;
`ifdef VGA_PGEN_BORDER_EN
  logic        s1_border;
`endif

  logic [11:0] bar_q;
  logic [2:0]  bar_idx;
  logic [23:0] pix;

  // A frame start loads the new mode and bumps the count; that same pixel
  // must already see the new values, so bypass the registers on that cycle.
  always_comb begin
    frame_start = Disp_activ && (Xpos == 12'd0) && (Ypos == 12'd0);
    eff_mode    = frame_start ? mode : active_mode;
    eff_cnt     = frame_start ? (frame_cnt + 8'd1) : frame_cnt;
  end

  // Frame-boundary state: mode only changes at frame start so frames never tear.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      active_mode <= 4'd0;
      frame_cnt   <= 8'd0;
    end else if (frame_start) begin
      active_mode <= mode;
      frame_cnt   <= frame_cnt + 8'd1;
    end
  end

  // Stage 1: capture everything the renderer needs for this pixel.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_x      <= 12'd0;
      s1_y_bit  <= 1'b0;
      s1_de     <= 1'b0;
      s1_mode   <= 4'd0;
      s1_cnt    <= 6'd0;
`ifdef VGA_PGEN_BORDER_EN
      s1_border <= 1'b0;
`endif
    end else begin
      s1_x      <= Xpos;
      s1_y_bit  <= Ypos[CHECK_LOG2];
      s1_de     <= Disp_activ;
      s1_mode   <= eff_mode;
      s1_cnt    <= eff_cnt[5:0];
`ifdef VGA_PGEN_BORDER_EN
      s1_border <= (Xpos == 12'd0) || (Xpos == 12'(H_ACTIVE - 1)) ||
                   (Ypos == 12'd0) || (Ypos == 12'(V_ACTIVE - 1));
`endif
    end
  end

  // Pattern renderer: pure function of the stage-1 values.
  always_comb begin
    pix     = 24'h000000;
    bar_q   = s1_x / 12'(BAR_W);
    bar_idx = (bar_q > 12'd7) ? 3'd7 : bar_q[2:0];
    case (s1_mode)
      4'd1: pix = 24'hFFFFFF;
      4'd2: begin
        case (bar_idx)
          3'd0:    pix = 24'hFFFFFF;
          3'd1:    pix = 24'hFFFF00;
          3'd2:    pix = 24'h00FFFF;
          3'd3:    pix = 24'h00FF00;
          3'd4:    pix = 24'hFF00FF;
          3'd5:    pix = 24'hFF0000;
          3'd6:    pix = 24'h0000FF;
          default: pix = 24'h000000;
        endcase
      end
      4'd3: pix = (s1_x[CHECK_LOG2] ^ s1_y_bit) ? 24'hFFFFFF : 24'h000000;
      4'd4: pix = {s1_x[7:0], s1_x[7:0], s1_x[7:0]};
      4'd5: pix = (s1_x[9:4] == s1_cnt) ? 24'hFFFFFF : 24'h000000;
      4'd6: pix = 24'hFF0000;
      4'd7: pix = 24'h00FF00;
      4'd8: pix = 24'h0000FF;
      default: pix = 24'h000000;
    endcase
`ifdef VGA_PGEN_BORDER_EN
    if (s1_border && (s1_mode != 4'd0)) pix = 24'hFFFFFF;
`endif
    if (!s1_de) pix = 24'h000000;
  end

  // Stage 2: register the rendered pixel and the delayed display-enable.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      R_o  <= 8'd0;
      G_o  <= 8'd0;
      B_o  <= 8'd0;
      de_o <= 1'b0;
    end else begin
      R_o  <= pix[23:16];
      G_o  <= pix[15:8];
      B_o  <= pix[7:0];
      de_o <= s1_de;
    end
  end

  assign frame_cnt_o = frame_cnt;

endmodule

// File: tb/tb_vga_pattern_gen.sv
// Self-checking bench for vga_pattern_gen: a reference model pushes the
// expected pixel into a scoreboard queue as each input is driven; the entry
// is popped and compared when the DUT presents that pixel two cycles later.
// Border expectations follow VGA_PGEN_BORDER_EN.
module tb_vga_pattern_gen;

  localparam int H_ACT = 640;
  localparam int V_ACT = 480;

  typedef struct {
    logic [23:0] rgb;
    logic        de;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [11:0] Xpos = 12'd0;
  logic [11:0] Ypos = 12'd0;
  logic        Disp_activ = 1'b0;
  logic [3:0]  mode = 4'd0;
  logic [7:0]  R_o, G_o, B_o;
  logic        de_o;
  logic [7:0]  frame_cnt_o;

  int checks = 0;
  int errors = 0;

  exp_t       sb[$];
  logic [3:0] model_mode = 4'd0;
  logic [7:0] model_cnt  = 8'd0;

  vga_pattern_gen dut (
    .clk(clk), .rst(rst), .Xpos(Xpos), .Ypos(Ypos), .Disp_activ(Disp_activ),
    .mode(mode), .R_o(R_o), .G_o(G_o), .B_o(B_o), .de_o(de_o),
    .frame_cnt_o(frame_cnt_o)
  );

  // Free-running pixel clock.
  always #5 clk = ~clk;

  function automatic logic [23:0] model_rgb(input logic [11:0] x, input logic [11:0] y,
                                            input logic d, input logic [3:0] m,
                                            input logic [7:0] cnt);
    logic [23:0] bars [8];
    int          idx;
    logic [23:0] c;
    bars = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
             24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};
    c = 24'h000000;
    case (m)
      4'd1: c = 24'hFFFFFF;
      4'd2: begin
        idx = int'(x) / 80;
        if (idx > 7) idx = 7;
        c = bars[idx];
      end
      4'd3: c = (x[5] != y[5]) ? 24'hFFFFFF : 24'h000000;
      4'd4: c = {x[7:0], x[7:0], x[7:0]};
      4'd5: c = (int'(x[9:4]) == int'(cnt) % 64) ? 24'hFFFFFF : 24'h000000;
      4'd6: c = 24'hFF0000;
      4'd7: c = 24'h00FF00;
      4'd8: c = 24'h0000FF;
      default: c = 24'h000000;
    endcase
`ifdef VGA_PGEN_BORDER_EN
    if (m != 4'd0 && (x == 0 || int'(x) == H_ACT - 1 || y == 0 || int'(y) == V_ACT - 1))
      c = 24'hFFFFFF;
`endif
    if (!d) c = 24'h000000;
    return c;
  endfunction

  // Drive one pixel, push its expectation, advance one clock and pop the
  // entry whose result is now on the outputs (the pixel driven one step earlier).
  task automatic applyStimulus(input int x, input int y, input logic d, input logic [3:0] m,
                               output exp_t e, output bit v);
    exp_t n;
    Xpos = 12'(x); Ypos = 12'(y); Disp_activ = d; mode = m;
    if (d && x == 0 && y == 0) begin
      model_mode = m;
      model_cnt  = model_cnt + 8'd1;
    end
    n.rgb = model_rgb(12'(x), 12'(y), d, model_mode, model_cnt);
    n.de  = d;
    sb.push_back(n);
    @(posedge clk); #1;
    v = 1'b0;
    e = n;
    if (sb.size() >= 2) begin
      e = sb.pop_front();
      v = 1'b1;
    end
  endtask

  task automatic test_reset;
    exp_t e; bit v;
    rst = 1'b0; mode = 4'd1; Xpos = 12'd0; Ypos = 12'd0;
    for (int i = 0; i < 5; i++) begin
      Disp_activ = (i % 2 == 0);
      @(posedge clk); #1;
      checks++;
      if ({R_o, G_o, B_o} !== 24'h0 || de_o !== 1'b0 || frame_cnt_o !== 8'd0) begin
        errors++;
        $display("[TB] FAIL reset_hold: rgb=%06h de=%b cnt=%0d expected 000000/0/0",
                 {R_o, G_o, B_o}, de_o, frame_cnt_o);
      end
    end
    rst = 1'b1;
    sb.delete(); model_mode = 4'd0; model_cnt = 8'd0;
    for (int i = 0; i < 4; i++) begin
      applyStimulus(5 + i, 5, 1'b1, 4'd3, e, v);
      if (v) begin
        checks++;
        if ({R_o, G_o, B_o} !== e.rgb || de_o !== e.de) begin
          errors++;
          $display("[TB] FAIL reset_mode0: rgb=%06h de=%b expected %06h/%b",
                   {R_o, G_o, B_o}, de_o, e.rgb, e.de);
        end
      end
    end
  endtask

  task automatic test_colour_bars;
    exp_t e; bit v;
    int xs [6] = '{0, 0, 79, 80, 400, 639};
    int ys [6] = '{0, 1, 1, 1, 1, 1};
    for (int i = 0; i < 8; i++) begin
      if (i < 6) applyStimulus(xs[i], ys[i], 1'b1, 4'd2, e, v);
      else       applyStimulus(700, 1, 1'b0, 4'd2, e, v);
      if (v) begin
        checks++;
        if ({R_o, G_o, B_o} !== e.rgb || de_o !== e.de) begin
          errors++;
          $display("[TB] FAIL colour_bars: rgb=%06h de=%b expected %06h/%b",
                   {R_o, G_o, B_o}, de_o, e.rgb, e.de);
        end
      end
    end
  endtask

  task automatic test_mid_frame_mode;
    exp_t e; bit v;
    applyStimulus(0, 0, 1'b1, 4'd1, e, v);
    for (int i = 0; i < 7; i++) begin
      if (i < 5)       applyStimulus(10 + i * 100, 100, 1'b1, 4'd6, e, v);
      else if (i == 5) applyStimulus(0, 0, 1'b1, 4'd6, e, v);
      else             applyStimulus(300, 0, 1'b1, 4'd6, e, v);
      if (v) begin
        checks++;
        if ({R_o, G_o, B_o} !== e.rgb || de_o !== e.de) begin
          errors++;
          $display("[TB] FAIL mid_frame_mode: rgb=%06h de=%b expected %06h/%b",
                   {R_o, G_o, B_o}, de_o, e.rgb, e.de);
        end
      end
    end
  endtask

  task automatic test_blanking;
    exp_t e; bit v;
    applyStimulus(0, 0, 1'b1, 4'd1, e, v);
    for (int i = 0; i < 6; i++) begin
      applyStimulus(698 + i, 3, (i % 3 == 1) ? 1'b1 : 1'b0, 4'd1, e, v);
      if (v) begin
        checks++;
        if ({R_o, G_o, B_o} !== e.rgb || de_o !== e.de) begin
          errors++;
          $display("[TB] FAIL blanking: rgb=%06h de=%b expected %06h/%b",
                   {R_o, G_o, B_o}, de_o, e.rgb, e.de);
        end
      end
    end
  endtask

  task automatic test_moving_bar;
    exp_t e; bit v;
    bit   probed = 1'b0;
    int   px [5] = '{47, 48, 63, 64, 100};
    for (int f = 0; f < 260; f++) begin
      applyStimulus(0, 0, 1'b1, 4'd5, e, v);
      if (v) begin
        checks++;
        if ({R_o, G_o, B_o} !== e.rgb || de_o !== e.de) begin
          errors++;
          $display("[TB] FAIL moving_bar_start: rgb=%06h de=%b expected %06h/%b",
                   {R_o, G_o, B_o}, de_o, e.rgb, e.de);
        end
      end
      checks++;
      if (frame_cnt_o !== model_cnt) begin
        errors++;
        $display("[TB] FAIL frame_cnt: got %0d expected %0d", frame_cnt_o, model_cnt);
      end
      if (model_cnt == 8'd3 && !probed) begin
        probed = 1'b1;
        for (int k = 0; k < 5; k++) begin
          applyStimulus(px[k], 7, 1'b1, 4'd5, e, v);
          if (v) begin
            checks++;
            if ({R_o, G_o, B_o} !== e.rgb || de_o !== e.de) begin
              errors++;
              $display("[TB] FAIL moving_bar_px: rgb=%06h de=%b expected %06h/%b",
                       {R_o, G_o, B_o}, de_o, e.rgb, e.de);
            end
          end
        end
      end
    end
  endtask

  task automatic test_mid_frame_reset;
    exp_t e; bit v;
    applyStimulus(0, 0, 1'b1, 4'd1, e, v);
    applyStimulus(20, 4, 1'b1, 4'd1, e, v);
    #2 rst = 1'b0;
    #1;
    checks++;
    if ({R_o, G_o, B_o} !== 24'h0 || de_o !== 1'b0 || frame_cnt_o !== 8'd0) begin
      errors++;
      $display("[TB] FAIL async_reset: rgb=%06h de=%b cnt=%0d expected 000000/0/0",
               {R_o, G_o, B_o}, de_o, frame_cnt_o);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    sb.delete(); model_mode = 4'd0; model_cnt = 8'd0;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) applyStimulus(0, 0, 1'b1, 4'd1, e, v);
      else        applyStimulus(30 + i, 9, 1'b1, 4'd1, e, v);
      if (v) begin
        checks++;
        if ({R_o, G_o, B_o} !== e.rgb || de_o !== e.de) begin
          errors++;
          $display("[TB] FAIL reset_resume: rgb=%06h de=%b expected %06h/%b",
                   {R_o, G_o, B_o}, de_o, e.rgb, e.de);
        end
      end
    end
  endtask

  task automatic test_border;
    exp_t e; bit v;
    int xs [7] = '{0, 0, 1, 639, 5, 0, 1};
    int ys [7] = '{0, 10, 10, 10, 479, 0, 10};
    logic [3:0] ms [7] = '{4'd6, 4'd6, 4'd6, 4'd6, 4'd6, 4'd0, 4'd0};
    for (int i = 0; i < 9; i++) begin
      if (i < 7) applyStimulus(xs[i], ys[i], 1'b1, ms[i], e, v);
      else       applyStimulus(800, 500, 1'b0, 4'd0, e, v);
      if (v) begin
        checks++;
        if ({R_o, G_o, B_o} !== e.rgb || de_o !== e.de) begin
          errors++;
          $display("[TB] FAIL border: rgb=%06h de=%b expected %06h/%b",
                   {R_o, G_o, B_o}, de_o, e.rgb, e.de);
        end
      end
    end
  endtask

  initial begin
    test_reset();
    test_colour_bars();
    test_mid_frame_mode();
    test_blanking();
    test_moving_bar();
    test_mid_frame_reset();
    test_border();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
